// File: rtl/sdram_test_pkg.sv
// Shared types and constants for the SDRAM pattern tester: command encoding,
// FSM states and Galois LFSR tap masks for the optional LFSR pattern source.
package sdram_test_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'h0,
        CMD_WRITE = 2'h1,
        CMD_READ  = 2'h2
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_GAP,
        ST_RD,
        ST_RD_GAP,
        ST_PAUSE
    } tester_state_e;

    // Right-shifting Galois masks of maximal-length polynomials
    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        case (width)
            8:       return {24'd0, LFSR_TAPS_8};
            16:      return {16'd0, LFSR_TAPS_16};
            default: return LFSR_TAPS_32;
        endcase
    endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// Pattern word source shared by the write and read phases; `load` restarts the
// sequence from a seed, `step` advances it. PATTERN_LFSR_EN selects a Galois LFSR.
module sdram_pattern_gen
    import sdram_test_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] word
);

    logic [DATA_W-1:0] word_q, word_d;

`ifdef PATTERN_LFSR_EN
    localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));

    logic [DATA_W-1:0] lfsr_next;

    always_comb begin
        lfsr_next = word_q >> 1;
        if (word_q[0]) begin
            lfsr_next = lfsr_next ^ TAPS;
        end
    end

    // Forcing bit 0 keeps a zero seed out of the LFSR lock-up state
    always_comb begin
        word_d = word_q;
        if (load) begin
            word_d = seed | DATA_W'(1);
        end else if (step) begin
            word_d = lfsr_next;
        end
    end
`else
    always_comb begin
        word_d = word_q;
        if (load) begin
            word_d = seed;
        end else if (step) begin
            word_d = word_q + DATA_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word = word_q;

endmodule

// File: rtl/sdram_pattern_tester.sv
// SDRAM write/read-back test engine: writes a seeded pattern over a window, reads
// it back and counts mismatches. Build with PATTERN_LFSR_EN for an LFSR pattern.
module sdram_pattern_tester
    import sdram_test_pkg::*;
#(
    parameter int ADDR_W    = 22,
    parameter int DATA_W    = 16,
    parameter int BASE_ADDR = 0,
    parameter int NUM_WORDS = 256,
    parameter int DELAY     = 24000000,
    parameter int LED_W     = 8,
    parameter int ERR_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              continuous,
    output logic [1:0]        command,
    output logic [ADDR_W-1:0] data_address,
    output logic [DATA_W-1:0] data_write,
    input  logic [DATA_W-1:0] data_read,
    input  logic              data_read_valid,
    input  logic              data_write_done,
    output logic [LED_W-1:0]  leds,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int CNT_W = (DELAY > 1) ? $clog2(DELAY) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DELAY - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    tester_state_e     state_q, state_d;
    cmd_e              cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LED_W-1:0]  leds_q, leds_d;
    logic              busy_q, busy_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [ADDR_W-1:0] first_q, first_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              gen_load;
    logic              gen_step;
    logic [DATA_W-1:0] pat_word;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    sdram_pattern_gen #(
        .DATA_W(DATA_W)
    ) u_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .load (gen_load),
        .step (gen_step),
        .seed (seed_d),
        .word (pat_word)
    );

    // The generator output tracks the current index, so it is both the write
    // data and the compare reference without a separate register.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        leds_d   = leds_q;
        busy_d   = busy_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        err_d    = err_q;
        first_d  = first_q;
        seed_d   = seed_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        gen_load = 1'b0;
        gen_step = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d    = '0;
                    first_d  = '0;
                    pass_d   = 1'b0;
                    fail_d   = 1'b0;
                    idx_d    = '0;
                    gen_load = 1'b1;
                    busy_d   = 1'b1;
                    cmd_d    = CMD_WRITE;
                    addr_d   = BASE;
                    state_d  = ST_WR;
                end
            end

            ST_WR: begin
                if (data_write_done) begin
                    cmd_d   = CMD_IDLE;
                    state_d = ST_WR_GAP;
                end
            end

            ST_WR_GAP: begin
                if (idx_q == LAST_IDX) begin
                    idx_d    = '0;
                    gen_load = 1'b1;
                    cmd_d    = CMD_READ;
                    state_d  = ST_RD;
                end else begin
                    idx_d    = idx_q + IDX_W'(1);
                    gen_step = 1'b1;
                    cmd_d    = CMD_WRITE;
                    state_d  = ST_WR;
                end
                addr_d = BASE + ADDR_W'(idx_d);
            end

            ST_RD: begin
                if (data_read_valid) begin
                    leds_d = data_read[LED_W-1:0];
                    if (data_read != pat_word) begin
                        err_d = sat_inc(err_q);
                        if (err_q == '0) begin
                            first_d = addr_q;
                        end
                    end
                    cmd_d   = CMD_IDLE;
                    state_d = ST_RD_GAP;
                end
            end

            // err_q already includes the final compare when the last gap is reached
            ST_RD_GAP: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    pass_d  = (err_q == '0);
                    fail_d  = (err_q != '0);
                    leds_d  = (err_q != '0) ? '1 : seed_q[LED_W-1:0];
                    state_d = ST_PAUSE;
                end else begin
                    idx_d    = idx_q + IDX_W'(1);
                    gen_step = 1'b1;
                    cmd_d    = CMD_READ;
                    addr_d   = BASE + ADDR_W'(idx_d);
                    state_d  = ST_RD;
                end
            end

            ST_PAUSE: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (continuous) begin
                        seed_d   = seed_q + DATA_W'(1);
                        err_d    = '0;
                        first_d  = '0;
                        idx_d    = '0;
                        gen_load = 1'b1;
                        cmd_d    = CMD_WRITE;
                        addr_d   = BASE;
                        state_d  = ST_WR;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                cmd_d   = CMD_IDLE;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_IDLE;
            addr_q  <= '0;
            leds_q  <= '0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
            seed_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            leds_q  <= leds_d;
            busy_q  <= busy_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
            first_q <= first_d;
            seed_q  <= seed_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign command        = cmd_q;
    assign data_address   = addr_q;
    assign data_write     = pat_word;
    assign leds           = leds_q;
    assign busy           = busy_q;
    assign pass           = pass_q;
    assign fail           = fail_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Scoreboard bench for sdram_pattern_tester: expected writes and pass results are
// queued by the stimulus and popped by the memory model and the result monitor.
`timescale 1ns/1ps
module tb_sdram_pattern_tester;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 16;
    localparam int LED_W  = 8;
    localparam int ERR_W  = 16;
    localparam int DELAY  = 3;
    localparam int LAT    = 1;
`ifdef PATTERN_LFSR_EN
    localparam int NW = 8;
`else
    localparam int NW = 4;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              continuous = 1'b0;
    logic [1:0]        command;
    logic [ADDR_W-1:0] data_address;
    logic [DATA_W-1:0] data_write;
    logic [DATA_W-1:0] data_read = '0;
    logic              data_read_valid = 1'b0;
    logic              data_write_done = 1'b0;
    logic [LED_W-1:0]  leds;
    logic              busy, pass, fail;
    logic [ERR_W-1:0]  err_count;
    logic [ADDR_W-1:0] first_err_addr;

    // 8-bit instance used to reach seed wrap-around within a short run
    logic       start8 = 1'b0, cont8 = 1'b0;
    logic [1:0] cmd8;
    logic [3:0] addr8, fea8;
    logic [7:0] wd8, leds8, err8;
    logic [7:0] rd8 = '0;
    logic       rv8 = 1'b0, wdn8 = 1'b0;
    logic       busy8, pass8, fail8;

    always #5 clk = ~clk;

    sdram_pattern_tester #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(0), .NUM_WORDS(NW),
        .DELAY(DELAY), .LED_W(LED_W), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .command(command), .data_address(data_address), .data_write(data_write),
        .data_read(data_read), .data_read_valid(data_read_valid),
        .data_write_done(data_write_done), .leds(leds), .busy(busy),
        .pass(pass), .fail(fail), .err_count(err_count), .first_err_addr(first_err_addr)
    );

    sdram_pattern_tester #(
        .ADDR_W(4), .DATA_W(8), .BASE_ADDR(0), .NUM_WORDS(4),
        .DELAY(1), .LED_W(8), .ERR_W(8)
    ) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .continuous(cont8),
        .command(cmd8), .data_address(addr8), .data_write(wd8),
        .data_read(rd8), .data_read_valid(rv8), .data_write_done(wdn8),
        .leds(leds8), .busy(busy8), .pass(pass8), .fail(fail8),
        .err_count(err8), .first_err_addr(fea8)
    );

    int checks = 0;
    int errors = 0;
    int res_seen = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct packed {
        logic              p;
        logic              f;
        logic [ERR_W-1:0]  err;
        logic [ADDR_W-1:0] first;
        logic [LED_W-1:0]  l;
        logic              last;
    } res_t;

    wr_t  exp_wr[$];
    res_t exp_res[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pat16(input logic [15:0] s, input int i);
`ifdef PATTERN_LFSR_EN
        logic [15:0] x = s | 16'h0001;
        for (int k = 0; k < i; k++) x = x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
        return x;
`else
        return s + 16'(i);
`endif
    endfunction

    function automatic logic [7:0] pat8(input logic [7:0] s, input int i);
`ifdef PATTERN_LFSR_EN
        logic [7:0] x = s | 8'h01;
        for (int k = 0; k < i; k++) x = x[0] ? ((x >> 1) ^ 8'hB8) : (x >> 1);
        return x;
`else
        return s + 8'(i);
`endif
    endfunction

    task automatic push_pass(input logic [15:0] seed);
        wr_t w;
        for (int i = 0; i < NW; i++) begin
            w.addr = ADDR_W'(i);
            w.data = pat16(seed, i);
            exp_wr.push_back(w);
        end
    endtask

    task automatic push_res(input logic p, input logic f, input logic [ERR_W-1:0] err,
                            input logic [ADDR_W-1:0] first, input logic [LED_W-1:0] l,
                            input logic last);
        res_t r;
        r.p = p; r.f = f; r.err = err; r.first = first; r.l = l; r.last = last;
        exp_res.push_back(r);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        repeat (2) @(negedge clk);
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle_timeout"}, busy, 0);
        repeat (2) @(negedge clk);
        chk({name, "_wr_left"}, exp_wr.size(), 0);
        chk({name, "_res_left"}, exp_res.size(), 0);
    endtask

    // Memory model for the main instance: answers each command after LAT extra cycles
    logic [DATA_W-1:0] mem [0:15];
    logic corrupt = 1'b0;

    initial begin
        int          wait_cnt = 0;
        logic        gap_due = 1'b0, gap_rd = 1'b0;
        logic [ADDR_W-1:0] last_addr = '0;
        logic [DATA_W-1:0] last_rd = '0;
        wr_t         e;
        forever begin
            @(negedge clk);
            data_write_done = 1'b0;
            data_read_valid = 1'b0;
            if (gap_due) begin
                chk("cmd_gap", command, 0);
                if (gap_rd) chk("leds_readback", leds, last_rd[LED_W-1:0]);
                gap_due = 1'b0;
                gap_rd  = 1'b0;
            end
            if (command == 2'd1 || command == 2'd2) begin
                if (wait_cnt > 0) chk("addr_stable", data_address, last_addr);
                last_addr = data_address;
                if (wait_cnt == LAT) begin
                    wait_cnt = 0;
                    gap_due  = 1'b1;
                    if (command == 2'd1) begin
                        mem[data_address[3:0]] = (corrupt && data_address == 2) ? 16'hDEAD : data_write;
                        data_write_done = 1'b1;
                        if (exp_wr.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL wr_unexpected: addr 0x%0h data 0x%0h, no write expected",
                                     data_address, data_write);
                        end else begin
                            e = exp_wr.pop_front();
                            chk("wr_addr", data_address, e.addr);
                            chk("wr_data", data_write, e.data);
                        end
                    end else begin
                        data_read       = mem[data_address[3:0]];
                        last_rd         = data_read;
                        data_read_valid = 1'b1;
                        gap_rd          = 1'b1;
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Result monitor: second consecutive idle-command cycle while busy is the first PAUSE cycle
    initial begin
        int   zc = 0;
        res_t r;
        forever begin
            @(negedge clk);
            if (busy && command == 2'd0) zc++;
            else zc = 0;
            if (zc == 2) begin
                if (exp_res.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL res_unexpected: pass=%0d fail=%0d err=%0d, no result expected",
                             pass, fail, err_count);
                end else begin
                    r = exp_res.pop_front();
                    chk("res_pass", pass, r.p);
                    chk("res_fail", fail, r.f);
                    chk("res_err_count", err_count, r.err);
                    chk("res_first_err_addr", first_err_addr, r.first);
                    chk("res_leds", leds, r.l);
                    res_seen++;
                    if (r.last) begin
                        repeat (DELAY - 1) @(negedge clk);
                        chk("busy_in_pause", busy, 1);
                        @(negedge clk);
                        chk("busy_drop", busy, 0);
                        zc = 0;
                    end
                end
            end
        end
    end

    // Model for the 8-bit instance: zero-latency memory, checks every write
    logic [7:0] mem8 [0:3];
    logic [7:0] fe_data [0:3];
    int wpass8 = 0;
    int widx8 = 0;

    initial begin
        forever begin
            @(negedge clk);
            wdn8 = 1'b0;
            rv8  = 1'b0;
            if (cmd8 == 2'd1) begin
                mem8[addr8[1:0]] = wd8;
                wdn8 = 1'b1;
                chk("u8_wr_addr", addr8, widx8);
                chk("u8_wr_data", wd8, pat8(8'(wpass8), widx8));
                if (wpass8 == 254) fe_data[widx8] = wd8;
                widx8++;
                if (widx8 == 4) begin
                    widx8 = 0;
                    wpass8++;
                end
            end else if (cmd8 == 2'd2) begin
                rd8 = mem8[addr8[1:0]];
                rv8 = 1'b1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rs0;
        logic [7:0] fe_exp [0:3];

        repeat (3) @(negedge clk);
        chk("rst_command", command, 0);
        chk("rst_address", data_address, 0);
        chk("rst_data_write", data_write, 0);
        chk("rst_leds", leds, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail", fail, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_first_err_addr", first_err_addr, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean single pass, seed 0
        push_pass(16'h0000);
        push_res(1'b1, 1'b0, 0, 0, 8'h00, 1'b1);
        pulse_start();
        wait_idle("t1");

        // Word at address 2 corrupted; a second start mid-run must be ignored
        corrupt = 1'b1;
        push_pass(16'h0000);
        push_res(1'b0, 1'b1, 1, 2, 8'hFF, 1'b1);
        pulse_start();
        repeat (5) @(negedge clk);
        pulse_start();
        wait_idle("t2");
        corrupt = 1'b0;

        // Two continuous passes: seeds 0 then 1
        push_pass(16'h0000);
        push_res(1'b1, 1'b0, 0, 0, 8'h00, 1'b0);
        push_pass(16'h0001);
        push_res(1'b1, 1'b0, 0, 0, 8'h01, 1'b1);
        rs0 = res_seen;
        continuous = 1'b1;
        pulse_start();
        n = 0;
        while (res_seen < rs0 + 1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        while (command != 2'd1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t3_second_pass_timeout", (n < 2000), 1);
        continuous = 1'b0;
        wait_idle("t3");

        // Reset asserted while the first write is being acknowledged (seed is 1)
        begin
            wr_t w;
            w.addr = '0;
            w.data = pat16(16'h0001, 0);
            exp_wr.push_back(w);
        end
        pulse_start();
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!data_write_done && n < 200);
        chk("t4_done_seen", data_write_done, 1);
        rst_n = 1'b0;
        #1;
        chk("t4_async_cmd", command, 0);
        chk("t4_async_busy", busy, 0);
        @(negedge clk);
        chk("t4_rst_command", command, 0);
        chk("t4_rst_address", data_address, 0);
        chk("t4_rst_data_write", data_write, 0);
        chk("t4_rst_leds", leds, 0);
        chk("t4_rst_pass", pass, 0);
        chk("t4_rst_fail", fail, 0);
        chk("t4_rst_err_count", err_count, 0);
        chk("t4_rst_first_err", first_err_addr, 0);
        chk("t4_wr_left", exp_wr.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_pass(16'h0000);
        push_res(1'b1, 1'b0, 0, 0, 8'h00, 1'b1);
        pulse_start();
        wait_idle("t4_clean");

        // Seed wrap on the 8-bit instance: run continuously until seed 0xFE
        cont8 = 1'b1;
        @(negedge clk) start8 = 1'b1;
        @(negedge clk) start8 = 1'b0;
        n = 0;
        while (wpass8 < 255 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        cont8 = 1'b0;
        chk("t5_reach_seed_fe", (wpass8 >= 255), 1);
        n = 0;
        while (busy8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t5_busy8", busy8, 0);
        chk("t5_pass8", pass8, 1);
        chk("t5_fail8", fail8, 0);
        chk("t5_err8", err8, 0);
        chk("t5_first_err8", fea8, 0);
        chk("t5_leds8", leds8, 8'hFE);
`ifdef PATTERN_LFSR_EN
        for (int i = 0; i < 4; i++) fe_exp[i] = pat8(8'hFE, i);
`else
        fe_exp[0] = 8'hFE;
        fe_exp[1] = 8'hFF;
        fe_exp[2] = 8'h00;
        fe_exp[3] = 8'h01;
`endif
        for (int i = 0; i < 4; i++) chk("t5_wrap_data", fe_data[i], fe_exp[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
